// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module     : pipeline_hazard_ctrl
// Description: LEGv8 5-stage pipeline sequencer: load-use stall, branch flush,
//              data-memory wait freeze with timeout. Optional macro PERF_CNT_EN
//              adds cycle/stall/flush performance counters.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int REG_IDX_W      = 5,
  parameter int BRANCH_PENALTY = 3,
  parameter int MEM_TIMEOUT    = 15,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_en,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 pc_src_im,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_bubble,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic                 flush_ie,
  output logic                 stall_all,
  output logic [2:0]           state_o,
  output logic                 mem_timeout_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int FLUSH_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY + 1) : 1;
  localparam logic [WAIT_W-1:0]    C_TIMEOUT    = WAIT_W'(MEM_TIMEOUT);
  localparam logic [FLUSH_W-1:0]   C_FLUSH_LOAD = FLUSH_W'(BRANCH_PENALTY - 1);
  localparam logic [REG_IDX_W-1:0] C_XZR        = {REG_IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_LDUSE   = 3'd2,
    S_FLUSH   = 3'd3,
    S_MEMWAIT = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t              r_state, w_state_n;
  logic [WAIT_W-1:0]   r_wait, w_wait_n;
  logic [FLUSH_W-1:0]  r_flush_left, w_flush_left_n;
  logic                r_err;
  logic                w_hazard;
  logic                w_mem_block;

  assign w_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != C_XZR) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign w_mem_block = dmem_req & ~dmem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_flush_left <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_wait       <= w_wait_n;
      r_flush_left <= w_flush_left_n;
      if (w_state_n == S_ERROR)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_wait_n        = r_wait;
    w_flush_left_n  = r_flush_left;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    idex_bubble     = 1'b0;
    flush_if        = 1'b0;
    flush_id        = 1'b0;
    flush_ie        = 1'b0;
    stall_all       = 1'b0;

    case (r_state)
      S_IDLE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        flush_if   = 1'b1;
        flush_id   = 1'b1;
        flush_ie   = 1'b1;
        if (run_en)
          w_state_n = S_RUN;
      end

      S_RUN, S_LDUSE, S_FLUSH: begin
        if (w_mem_block) begin
          stall_all  = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          w_state_n  = S_MEMWAIT;
          w_wait_n   = WAIT_W'(1);
        end else if (pc_src_im && (r_state != S_FLUSH)) begin
          // pc_write stays high so the PC captures the branch target now
          flush_if       = 1'b1;
          flush_id       = 1'b1;
          flush_ie       = 1'b1;
          w_flush_left_n = C_FLUSH_LOAD;
          w_state_n      = (BRANCH_PENALTY > 1) ? S_FLUSH : S_RUN;
        end else if (w_hazard && (r_state == S_RUN)) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          w_state_n   = S_LDUSE;
        end else if (!run_en) begin
          w_state_n = S_IDLE;
        end else if (r_state == S_FLUSH) begin
          w_flush_left_n = r_flush_left - 1'b1;
          if (r_flush_left <= FLUSH_W'(1))
            w_state_n = S_RUN;
        end else begin
          w_state_n = S_RUN;
        end
      end

      S_MEMWAIT: begin
        if (dmem_ready) begin
          w_state_n = run_en ? S_RUN : S_IDLE;
        end else begin
          stall_all  = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (r_wait == C_TIMEOUT)
            w_state_n = S_ERROR;
          else
            w_wait_n = r_wait + 1'b1;
        end
      end

      S_ERROR: begin
        stall_all  = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign state_o         = r_state;
  assign mem_timeout_err = r_err;

`ifdef PERF_CNT_EN
  logic w_br_taken;

  // A branch is accepted only where the control block actually flushed for it
  assign w_br_taken = pc_src_im & ~w_mem_block &
                      ((r_state == S_RUN) | (r_state == S_LDUSE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (r_state != S_IDLE) begin
        cycle_cnt <= cycle_cnt + 1'b1;
        if (!pc_write)
          stall_cnt <= stall_cnt + 1'b1;
      end
      if (w_br_taken)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module     : tb_pipeline_hazard_ctrl
// Description: Scoreboard bench for pipeline_hazard_ctrl with a behavioural model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int BP = 3;
  localparam int TO = 15;

  typedef struct packed {
    logic       rst_n;
    logic       run_en;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       pc_src_im;
    logic       dmem_req;
    logic       dmem_ready;
  } stim_t;

  logic clk = 1'b0;
  logic reset, run_en, id_valid, id_uses_rs2, ex_valid, ex_mem_read;
  logic pc_src_im, dmem_req, dmem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_write, ifid_write, idex_bubble, flush_if, flush_id, flush_ie, stall_all;
  logic [2:0] state_o;
  logic mem_timeout_err;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_IDX_W(5), .BRANCH_PENALTY(BP), .MEM_TIMEOUT(TO), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .pc_src_im(pc_src_im), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ie(flush_ie),
    .stall_all(stall_all), .state_o(state_o), .mem_timeout_err(mem_timeout_err)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Behavioural reference: mode names, remaining-wait and ignore-branch budgets
  int  m_mode;      // 0 idle 1 run 2 after-bubble 3 branch-shadow 4 memwait 5 error
  int  m_waited;
  int  m_shadow;
  bit  m_err;

  task automatic model_step(input stim_t s, output logic [10:0] e);
    bit pcw = 1, ifw = 1, bub = 0, fl = 0, stall = 0;
    int nxt;
    bit hz;
    if (!s.rst_n) begin
      m_mode = 0; m_waited = 0; m_shadow = 0; m_err = 0;
      e = {3'd0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
      return;
    end
    nxt = m_mode;
    hz = s.id_valid && s.ex_valid && s.ex_mem_read && (s.ex_rd != 5'd31) &&
         ((s.ex_rd == s.id_rs1) || (s.id_uses_rs2 && (s.ex_rd == s.id_rs2)));
    if (m_mode == 0) begin
      pcw = 0; ifw = 0; fl = 1;
      if (s.run_en) nxt = 1;
    end else if (m_mode >= 1 && m_mode <= 3) begin
      if (s.dmem_req && !s.dmem_ready) begin
        stall = 1; pcw = 0; ifw = 0; nxt = 4; m_waited = 1;
      end else if (s.pc_src_im && m_mode != 3) begin
        fl = 1; m_shadow = BP - 1; nxt = (BP > 1) ? 3 : 1;
      end else if (hz && m_mode == 1) begin
        pcw = 0; ifw = 0; bub = 1; nxt = 2;
      end else if (!s.run_en) begin
        nxt = 0;
      end else if (m_mode == 3) begin
        m_shadow = m_shadow - 1;
        if (m_shadow == 0) nxt = 1;
      end else begin
        nxt = 1;
      end
    end else if (m_mode == 4) begin
      if (s.dmem_ready) nxt = s.run_en ? 1 : 0;
      else begin
        stall = 1; pcw = 0; ifw = 0;
        if (m_waited == TO) nxt = 5;
        else m_waited = m_waited + 1;
      end
    end else begin
      stall = 1; pcw = 0; ifw = 0;
    end
    e = {3'(m_mode), pcw, ifw, bub, fl, fl, fl, stall, m_err};
    if (nxt == 5) m_err = 1;
    m_mode = nxt;
  endtask

  task automatic drive(input stim_t s);
    logic [10:0] e;
    @(posedge clk);
    #1;
    reset = s.rst_n; run_en = s.run_en; id_valid = s.id_valid;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_uses_rs2 = s.id_uses_rs2;
    ex_valid = s.ex_valid; ex_mem_read = s.ex_mem_read; ex_rd = s.ex_rd;
    pc_src_im = s.pc_src_im; dmem_req = s.dmem_req; dmem_ready = s.dmem_ready;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t quiet();
    stim_t s = '0;
    s.rst_n = 1'b1;
    s.run_en = 1'b1;
    return s;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd5;
      1: return 5'd31;
      2: return 5'd6;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  always @(negedge clk) begin
    logic [10:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {state_o, pc_write, ifid_write, idex_bubble, flush_if, flush_id,
           flush_ie, stall_all, mem_timeout_err};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got st=%0d pcw/ifw/bub/fl3/stall/err=%b required st=%0d pcw/ifw/bub/fl3/stall/err=%b",
                 $time, g[10:8], g[7:0], e[10:8], e[7:0]);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0; run_en = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs2 = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    pc_src_im = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    m_mode = 0; m_waited = 0; m_shadow = 0; m_err = 0;

    s = quiet(); s.rst_n = 1'b0;
    repeat (3) drive(s);
    s = quiet();
    repeat (3) drive(s);

    // load-use on rs1, then non-hazards (XZR and unused rs2)
    s = quiet(); s.id_valid = 1; s.ex_valid = 1; s.ex_mem_read = 1;
    s.ex_rd = 5'd5; s.id_rs1 = 5'd5; s.id_rs2 = 5'd9; s.id_uses_rs2 = 1;
    repeat (2) drive(s);
    s.ex_rd = 5'd31; s.id_rs1 = 5'd31;
    repeat (2) drive(s);
    s.ex_rd = 5'd5; s.id_rs1 = 5'd7; s.id_rs2 = 5'd5; s.id_uses_rs2 = 0;
    repeat (2) drive(s);

    // taken branch held three cycles
    s = quiet(); s.pc_src_im = 1;
    repeat (3) drive(s);
    s = quiet();
    repeat (2) drive(s);

    // memory wait four cycles with a pending hazard, then ready
    s = quiet(); s.dmem_req = 1; s.id_valid = 1; s.ex_valid = 1;
    s.ex_mem_read = 1; s.ex_rd = 5'd4; s.id_rs1 = 5'd4;
    repeat (4) drive(s);
    s.dmem_ready = 1;
    drive(s);
    s = quiet();
    repeat (2) drive(s);

    // never-ready memory into ERROR, then async reset out of it
    s = quiet(); s.dmem_req = 1;
    repeat (20) drive(s);
    s.rst_n = 0;
    drive(s);
    s = quiet();
    repeat (3) drive(s);

    for (int i = 0; i < 3000; i++) begin
      s.rst_n       = ($urandom_range(0, 149) != 0);
      s.run_en      = ($urandom_range(0, 19) != 0);
      s.id_valid    = ($urandom_range(0, 3) != 0);
      s.ex_valid    = ($urandom_range(0, 3) != 0);
      s.ex_mem_read = 1'($urandom_range(0, 1));
      s.id_rs1      = pick_reg();
      s.id_rs2      = pick_reg();
      s.ex_rd       = pick_reg();
      s.id_uses_rs2 = 1'($urandom_range(0, 1));
      s.pc_src_im   = ($urandom_range(0, 7) == 0);
      s.dmem_req    = ($urandom_range(0, 3) == 0);
      s.dmem_ready  = ($urandom_range(0, 3) != 0);
      drive(s);
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
